// File: rtl/ad7606_ser_emu.sv
// AD7606 serial-interface responder: convst-triggered busy window followed by
// an MSB-first 8-channel frame on one data line, clocked out by ad_rd falling edges.
module ad7606_ser_emu #(
    parameter int CONV_CYCLES = 200,
    parameter int DW          = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            convst,
    input  logic            ad_cs,
    input  logic            ad_rd,
    input  logic            ad_rst,
    input  logic [2:0]      ad_os,
    input  logic [8*DW-1:0] ch_data,
    output logic            ad_busy,
    output logic            firstdata,
    output logic            ad_data_out,
    output logic            frame_done
);
    localparam int FW = 8 * DW;
    localparam int IW = $clog2(FW + 1);
    localparam int CW = $clog2(CONV_CYCLES * 64 + 1);
    localparam logic [IW-1:0] FW_I   = IW'(FW);
    localparam logic [IW-1:0] LAST_I = IW'(FW - 1);
    localparam logic [IW-1:0] DW_I   = IW'(DW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_n_s;
    logic            convst_r;
    logic            cs_r;
    logic            rd_r;
    logic [FW-1:0]   frame_r;
    logic [IW-1:0]   idx_r;
    logic [IW-1:0]   idx_n_s;
    logic [CW-1:0]   cnt_r;
    logic [2:0]      os_r;
    logic            busy_r;
    logic            first_r;
    logic            dout_r;
    logic            done_r;
    logic            done_n_s;
    logic            convst_rise_s;
    logic            rd_fall_s;
    logic [CW-1:0]   conv_len_s;
    logic [FW-1:0]   shifted_s;

    assign convst_rise_s = convst & ~convst_r;
    assign rd_fall_s     = ~ad_rd & rd_r;
    assign conv_len_s    = CW'(CONV_CYCLES) << os_r;
    // The bit at the post-update index sits at the top after shifting.
    assign shifted_s     = frame_r << idx_n_s;

    assign ad_busy     = busy_r;
    assign firstdata   = first_r;
    assign ad_data_out = dout_r;
    assign frame_done  = done_r;

    // Next-state and read-index logic.
    always_comb begin
        state_n_s = state_r;
        idx_n_s   = idx_r;
        done_n_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (convst_rise_s) begin
                    state_n_s = CONV;
                    idx_n_s   = {IW{1'b0}};
                end else begin
                    state_n_s = IDLE;
                end
            end
            CONV: begin
                if (cnt_r == conv_len_s) begin
                    state_n_s = READY;
                end else begin
                    state_n_s = CONV;
                end
            end
            READY: begin
                if (convst_rise_s) begin
                    state_n_s = CONV;
                    idx_n_s   = {IW{1'b0}};
                end else if (rd_fall_s && !cs_r && (idx_r != FW_I)) begin
                    // cs_r gates the shift so an rd edge coinciding with CS release still counts.
                    idx_n_s  = idx_r + IW'(1);
                    done_n_s = (idx_r == LAST_I);
                end else begin
                    idx_n_s = idx_r;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State, capture, counters and registered outputs; ad_rst mirrors rst_n synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            convst_r <= 1'b0;
            cs_r     <= 1'b1;
            rd_r     <= 1'b1;
            frame_r  <= {FW{1'b0}};
            idx_r    <= {IW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            os_r     <= 3'd0;
            busy_r   <= 1'b0;
            first_r  <= 1'b0;
            dout_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (ad_rst) begin
            state_r  <= IDLE;
            convst_r <= 1'b0;
            cs_r     <= 1'b1;
            rd_r     <= 1'b1;
            frame_r  <= {FW{1'b0}};
            idx_r    <= {IW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            os_r     <= 3'd0;
            busy_r   <= 1'b0;
            first_r  <= 1'b0;
            dout_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            convst_r <= convst;
            cs_r     <= ad_cs;
            rd_r     <= ad_rd;
            state_r  <= state_n_s;
            idx_r    <= idx_n_s;
            done_r   <= done_n_s;
            if (convst_rise_s && (state_r != CONV)) begin
                frame_r <= ch_data;
                os_r    <= (ad_os == 3'd7) ? 3'd0 : ad_os;
                cnt_r   <= {CW{1'b0}};
            end else if (state_r == CONV) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            busy_r  <= (state_r == CONV) && (cnt_r != conv_len_s);
            first_r <= (state_n_s == READY) && !ad_cs && (idx_n_s < DW_I);
            dout_r  <= (state_n_s == READY) && !ad_cs && (idx_n_s != FW_I) && shifted_s[FW-1];
        end
    end
endmodule

// File: tb/tb_ad7606_ser_emu.sv
// Self-checking bench for ad7606_ser_emu: table of conversion/read scenarios,
// randomized frames against a bit-list reference model, and reset corner cases.
module tb_ad7606_ser_emu;
    localparam int CC = 10;
    localparam int DW = 16;
    localparam int FW = 8 * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          convst;
    logic          ad_cs;
    logic          ad_rd;
    logic          ad_rst;
    logic [2:0]    ad_os;
    logic [FW-1:0] ch_data;
    logic          ad_busy;
    logic          firstdata;
    logic          ad_data_out;
    logic          frame_done;

    int            checks = 0;
    int            errors = 0;
    logic [FW-1:0] exp_frame;
    logic [FW-1:0] got;
    int            exp_idx;
    int            done_cnt;
    int            first_cnt;

    typedef struct {
        logic [2:0]    os;
        logic [FW-1:0] data;
        int            split;
        int            gap;
        bit            simul;
        int            glitch;
        int            exp_w;
    } vec_t;
    vec_t vecs [5];

    ad7606_ser_emu #(.CONV_CYCLES(CC), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .convst(convst), .ad_cs(ad_cs), .ad_rd(ad_rd),
        .ad_rst(ad_rst), .ad_os(ad_os), .ch_data(ch_data), .ad_busy(ad_busy),
        .firstdata(firstdata), .ad_data_out(ad_data_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: run still going at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the frame is a bit list, index 0 = ch1 MSB; past the end reads 0.
    task automatic sample();
        logic expbit;
        expbit = (exp_idx < FW) ? exp_frame[FW-1-exp_idx] : 1'b0;
        chk("dout", ad_data_out, expbit);
        chk("firstdata", firstdata, (exp_idx < DW) ? 1'b1 : 1'b0);
        if (exp_idx < FW) got[FW-1-exp_idx] = ad_data_out;
        if (firstdata) first_cnt++;
    endtask

    task automatic cs_low();
        ad_cs = 1'b0;
        tick();
        sample();
    endtask

    task automatic cs_high(input int n);
        ad_cs = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("dout_cs_high", ad_data_out, 1'b0);
            chk("first_cs_high", firstdata, 1'b0);
        end
    endtask

    task automatic rd_edge(input bit with_cs_rise);
        logic exp_done;
        ad_rd = 1'b0;
        if (with_cs_rise) ad_cs = 1'b1;
        tick();
        if (exp_idx < FW) begin
            exp_idx++;
            exp_done = (exp_idx == FW);
        end else begin
            exp_done = 1'b0;
        end
        chk("frame_done", frame_done, exp_done);
        if (frame_done) done_cnt++;
        if (!ad_cs) sample();
        else chk("dout_cs_rise", ad_data_out, 1'b0);
        ad_rd = 1'b1;
        tick();
        chk("done_width", frame_done, 1'b0);
    endtask

    task automatic run_conv(input logic [2:0] os, input logic [FW-1:0] data, input int glitch,
                            input bit noise, output int width);
        int w;
        bit bad;
        exp_frame = data;
        exp_idx   = 0;
        ad_os     = os;
        ch_data   = data;
        convst    = 1'b1;
        tick();
        chk("busy_lat0", ad_busy, 1'b0);
        convst  = 1'b0;
        ad_os   = 3'($urandom);
        ch_data = ~data;
        if (noise) ad_cs = 1'b0;
        tick();
        chk("busy_lat1", ad_busy, 1'b1);
        w   = 1;
        bad = 1'b0;
        for (int i = 0; i < 20000 && ad_busy; i++) begin
            if (ad_data_out || firstdata || frame_done) bad = 1'b1;
            convst = (w == glitch) ? 1'b1 : 1'b0;
            if (noise) ad_rd = ~ad_rd;
            tick();
            if (ad_busy) w++;
        end
        chk("busy_timeout", ad_busy, 1'b0);
        chk("conv_quiet", bad, 1'b0);
        convst = 1'b0;
        ad_cs  = 1'b1;
        ad_rd  = 1'b1;
        tick();
        width = w;
    endtask

    task automatic read_frame(input int split, input int gap, input bit simul, input bit rnd);
        got       = '0;
        done_cnt  = 0;
        first_cnt = 0;
        cs_low();
        for (int e = 0; e < FW + 2; e++) begin
            if (e + 1 == split) begin
                if (simul) rd_edge(1'b1);
                cs_high(gap);
                cs_low();
                if (simul) continue;
            end else if (rnd && ($urandom_range(0, 15) == 0)) begin
                cs_high($urandom_range(1, 4));
                cs_low();
            end
            rd_edge(1'b0);
            if (rnd) repeat ($urandom_range(0, 2)) tick();
        end
        chk("stream", got, exp_frame);
        chk("done_once", done_cnt, 1);
        if (split == 0 && !rnd) chk("first_count", first_cnt, DW);
        cs_high(1);
    endtask

    initial begin
        int  w;
        bit  bad;
        logic [2:0] os;
        logic [FW-1:0] data;

        vecs[0] = '{3'd0, {16'hA5C3, 16'h0001, 16'h0002, 16'h0004, 16'h0010, 16'h0100, 16'h1000, 16'h8000},
                    0, 0, 1'b0, 0, 10};
        vecs[1] = '{3'd3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 40, 20, 1'b0, 0, 80};
        vecs[2] = '{3'd7, 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0, 0, 0, 1'b0, 4, 10};
        vecs[3] = '{3'd1, 128'hF0F0_0F0F_AAAA_5555_C3C3_3C3C_8001_7FFE, 6, 3, 1'b1, 0, 20};
        vecs[4] = '{3'd6, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 100, 5, 1'b0, 0, 640};

        rst_n = 1'b0; convst = 1'b0; ad_cs = 1'b1; ad_rd = 1'b1; ad_rst = 1'b0;
        ad_os = 3'd0; ch_data = '0;
        #1;
        chk("rst_busy", ad_busy, 1'b0);
        chk("rst_first", firstdata, 1'b0);
        chk("rst_dout", ad_data_out, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // rd/cs activity while idle must not produce data.
        bad = 1'b0;
        ad_cs = 1'b0;
        repeat (4) begin
            ad_rd = 1'b0; tick();
            if (ad_data_out || firstdata || frame_done || ad_busy) bad = 1'b1;
            ad_rd = 1'b1; tick();
        end
        chk("idle_quiet", bad, 1'b0);
        ad_cs = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            run_conv(vecs[v].os, vecs[v].data, vecs[v].glitch, 1'b0, w);
            chk("busy_width", w, vecs[v].exp_w);
            read_frame(vecs[v].split, vecs[v].gap, vecs[v].simul, 1'b0);
        end

        // Abort a partial read with a new conversion; new data restarts from bit 0.
        run_conv(3'd0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 1'b0, w);
        cs_low();
        repeat (49) rd_edge(1'b0);
        run_conv(3'd2, 128'h9E37_79B9_7F4A_7C15_F39C_C060_5CED_C834, 0, 1'b0, w);
        chk("abort_width", w, 40);
        read_frame(0, 0, 1'b0, 1'b0);

        for (int it = 0; it < 6; it++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            os   = 3'($urandom_range(0, 7));
            run_conv(os, data, 0, 1'b1, w);
            chk("rand_width", w, CC << ((os == 3'd7) ? 0 : int'(os)));
            read_frame(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 127)),
                       $urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'b1);
        end

        // Synchronous ad_rst mid-conversion returns to idle.
        ch_data = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        ad_os = 3'd2;
        convst = 1'b1; tick();
        convst = 1'b0;
        repeat (5) tick();
        chk("arst_pre_busy", ad_busy, 1'b1);
        ad_rst = 1'b1;
        tick();
        chk("srst_busy", ad_busy, 1'b0);
        chk("srst_dout", ad_data_out, 1'b0);
        chk("srst_first", firstdata, 1'b0);
        chk("srst_done", frame_done, 1'b0);
        tick();
        ad_rst = 1'b0;
        bad = 1'b0;
        ad_cs = 1'b0;
        repeat (30) begin
            ad_rd = ~ad_rd; tick();
            if (ad_data_out || firstdata || frame_done || ad_busy) bad = 1'b1;
        end
        chk("srst_quiet", bad, 1'b0);
        ad_cs = 1'b1; ad_rd = 1'b1;
        tick();

        // Asynchronous rst_n mid-read clears outputs without a clock edge.
        run_conv(3'd0, 128'hFFFF_0000_0000_0000_0000_0000_0000_0000, 0, 1'b0, w);
        cs_low();
        repeat (5) rd_edge(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", ad_busy, 1'b0);
        chk("arst_first", firstdata, 1'b0);
        chk("arst_dout", ad_data_out, 1'b0);
        chk("arst_done", frame_done, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        bad = 1'b0;
        repeat (4) begin
            ad_rd = 1'b0; tick();
            if (ad_data_out || firstdata || frame_done || ad_busy) bad = 1'b1;
            ad_rd = 1'b1; tick();
        end
        chk("arst_quiet", bad, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
